// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/commit stage.
// Holds rd source codes, CSR addresses, trap cause and FSM encoding.
package wb_pkg;

   localparam logic [2:0] SRC_NONE = 3'd0;
   localparam logic [2:0] SRC_ALU  = 3'd1;
   localparam logic [2:0] SRC_MEM  = 3'd2;
   localparam logic [2:0] SRC_SNPC = 3'd3;
   localparam logic [2:0] SRC_CSR  = 3'd4;
   localparam logic [2:0] SRC_CMP  = 3'd5;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic [31:0] ECALL_M = 32'd11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_WRITE  = 2'b01,
      ST_COMMIT = 2'b10
   } state_e;

   typedef struct packed {
      logic [31:0] dnpc;
      logic [31:0] snpc;
      logic [31:0] pc;
      logic [2:0]  src;
      logic [31:0] mdata;
      logic [31:0] alu;
      logic [31:0] csr;
      logic [31:0] src2;
      logic [11:0] csraddr;
      logic        cmp;
      logic        ecall;
      logic [4:0]  rd;
   } wb_bundle_t;

endpackage

// File: rtl/wb_gprfile.sv
// Architectural GPR file: one write port, two combinational read ports.
// Ports: clk/rst (async low), we/waddr/wdata, raddr1/2 -> rdata1/2; x0 reads 0.
module wb_gprfile #(
   parameter int NGPR = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr1_i,
   input  logic [4:0]  raddr2_i,
   output logic [31:0] rdata1_o,
   output logic [31:0] rdata2_o
);

   logic [31:0] regs_q [NGPR];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NGPR; i++) regs_q[i] <= '0;
      end else if (we_i && waddr_i != 5'd0) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs_q[raddr1_i];
   assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs_q[raddr2_i];

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: captures an M->W bundle, writes GPR/CSRs, then
// offers {commit_pc, commit_npc} to the IFU. Owns GPRs and machine CSRs.
module wb_commit
   import wb_pkg::*;
#(
   parameter int          NGPR          = 32,
   parameter logic [31:0] RESET_MSTATUS = 32'h0000_1800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [31:0] dnpcW,
   input  logic [31:0] snpcW,
   input  logic [31:0] pcW,
   input  logic [2:0]  rdregsrcW,
   input  logic [31:0] mdataW,
   input  logic [31:0] ALU_resultW,
   input  logic [31:0] csrW,
   input  logic [31:0] src2W,
   input  logic [11:0] csraddrW,
   input  logic        cmp_resultW,
   input  logic        ecallW,
   input  logic [4:0]  rdW,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data,
   input  logic [11:0] csr_raddr,
   output logic [31:0] csr_rdata,
   output logic        commit_valid,
   input  logic        commit_ready,
   output logic [31:0] commit_pc,
   output logic [31:0] commit_npc
);

   state_e      state_q, state_d;
   wb_bundle_t  b_q, b_d;
   logic [31:0] mstatus_q, mtvec_q, mepc_q, mcause_q;
   logic [31:0] cpc_q, cnpc_q;
   logic        accept, wr_act;
   logic        gpr_we, has_rd;
   logic [31:0] gpr_wdata;

   assign s_ready = rst && (state_q == ST_IDLE);
   assign accept  = s_ready && s_valid;
   assign wr_act  = (state_q == ST_WRITE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (s_valid) state_d = ST_WRITE;
         ST_WRITE:  state_d = ST_COMMIT;
         ST_COMMIT: if (commit_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      b_d = b_q;
      if (accept) begin
         b_d.dnpc    = dnpcW;
         b_d.snpc    = snpcW;
         b_d.pc      = pcW;
         b_d.src     = rdregsrcW;
         b_d.mdata   = mdataW;
         b_d.alu     = ALU_resultW;
         b_d.csr     = csrW;
         b_d.src2    = src2W;
         b_d.csraddr = csraddrW;
         b_d.cmp     = cmp_resultW;
         b_d.ecall   = ecallW;
         b_d.rd      = rdW;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
      end
   end

   always_comb begin
      has_rd    = 1'b1;
      gpr_wdata = 32'd0;
      case (b_q.src)
         SRC_ALU:  gpr_wdata = b_q.alu;
         SRC_MEM:  gpr_wdata = b_q.mdata;
         SRC_SNPC: gpr_wdata = b_q.snpc;
         SRC_CSR:  gpr_wdata = b_q.csr;
         SRC_CMP:  gpr_wdata = {31'b0, b_q.cmp};
         default:  has_rd = 1'b0;
      endcase
   end

   // An ecall bundle ignores its rd source entirely.
   assign gpr_we = wr_act && !b_q.ecall && has_rd && (b_q.rd != 5'd0);

   wb_gprfile #(.NGPR(NGPR)) u_gpr (
      .clk      (clk),
      .rst      (rst),
      .we_i     (gpr_we),
      .waddr_i  (b_q.rd),
      .wdata_i  (gpr_wdata),
      .raddr1_i (rs1_addr),
      .raddr2_i (rs2_addr),
      .rdata1_o (rs1_data),
      .rdata2_o (rs2_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mstatus_q <= RESET_MSTATUS;
         mtvec_q   <= '0;
         mepc_q    <= '0;
         mcause_q  <= '0;
      end else if (wr_act) begin
         if (b_q.ecall) begin
            mepc_q   <= b_q.pc;
            mcause_q <= ECALL_M;
         end else if (b_q.src == SRC_CSR) begin
            case (b_q.csraddr)
               CSR_MSTATUS: mstatus_q <= b_q.src2;
               CSR_MTVEC:   mtvec_q   <= b_q.src2;
               CSR_MEPC:    mepc_q    <= b_q.src2;
               CSR_MCAUSE:  mcause_q  <= b_q.src2;
               default:     ;
            endcase
         end
      end
   end

   always_comb begin
      csr_rdata = 32'd0;
      case (csr_raddr)
         CSR_MSTATUS: csr_rdata = mstatus_q;
         CSR_MTVEC:   csr_rdata = mtvec_q;
         CSR_MEPC:    csr_rdata = mepc_q;
         CSR_MCAUSE:  csr_rdata = mcause_q;
         default:     csr_rdata = 32'd0;
      endcase
   end

   // Commit record is latched with the architectural write so it is
   // stable for the whole COMMIT state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cpc_q  <= '0;
         cnpc_q <= '0;
      end else if (wr_act) begin
         cpc_q  <= b_q.pc;
         cnpc_q <= b_q.ecall ? mtvec_q : b_q.dnpc;
      end
   end

   assign commit_valid = (state_q == ST_COMMIT);
   assign commit_pc    = cpc_q;
   assign commit_npc   = cnpc_q;

endmodule

// File: tb/tb_wb_commit.sv
// Randomized scoreboard bench for wb_commit.
// Stimulus pushes model expectations; a monitor checks each commit.
module tb_wb_commit;

   logic        clk = 0;
   logic        rst = 0;
   logic        s_valid = 0;
   logic        s_ready;
   logic [31:0] dnpcW = 0, snpcW = 0, pcW = 0;
   logic [2:0]  rdregsrcW = 0;
   logic [31:0] mdataW = 0, ALU_resultW = 0, csrW = 0, src2W = 0;
   logic [11:0] csraddrW = 0;
   logic        cmp_resultW = 0, ecallW = 0;
   logic [4:0]  rdW = 0;
   logic [4:0]  rs1_addr = 0, rs2_addr = 0;
   logic [31:0] rs1_data, rs2_data;
   logic [11:0] csr_raddr, mon_raddr = 0, main_raddr = 0;
   logic        main_sel = 1;
   logic [31:0] csr_rdata;
   logic        commit_valid;
   logic        commit_ready = 0;
   logic [31:0] commit_pc, commit_npc;

   assign csr_raddr = main_sel ? main_raddr : mon_raddr;

   wb_commit dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
      .dnpcW(dnpcW), .snpcW(snpcW), .pcW(pcW), .rdregsrcW(rdregsrcW),
      .mdataW(mdataW), .ALU_resultW(ALU_resultW), .csrW(csrW),
      .src2W(src2W), .csraddrW(csraddrW), .cmp_resultW(cmp_resultW),
      .ecallW(ecallW), .rdW(rdW), .rs1_addr(rs1_addr),
      .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
      .commit_valid(commit_valid), .commit_ready(commit_ready),
      .commit_pc(commit_pc), .commit_npc(commit_npc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, dnpc, snpc, mdata, alu, csr, src2;
      logic [11:0] ca;
      logic [2:0]  src;
      logic        cmp, ec;
      logic [4:0]  rd;
   } bun_t;

   typedef struct {
      logic [31:0] pc, npc, rv, cv0, cv1;
      logic [4:0]  rd;
      logic [11:0] ca0, ca1;
      int          acc, stall;
   } exp_t;

   exp_t q[$];
   int cnt = 0, bad = 0, cyc = 0;
   logic mon_en = 1;

   logic [31:0] m_gpr [32];
   logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      cnt++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, req, $time);
      end
   endtask

   function automatic logic [31:0] mcsr(logic [11:0] a);
      case (a)
         12'h300: return m_mstatus;
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_gpr[i] = 0;
      m_mstatus = 32'h1800;
      m_mtvec = 0;
      m_mepc = 0;
      m_mcause = 0;
   endtask

   // Architectural effect of one retired instruction.
   task automatic model_step(bun_t b, int stall, int acc);
      exp_t e;
      logic [31:0] v;
      bit has;
      e.pc = b.pc;
      e.rd = b.rd;
      e.acc = acc;
      e.stall = stall;
      if (b.ec) begin
         m_mepc = b.pc;
         m_mcause = 11;
         e.npc = m_mtvec;
         e.ca0 = 12'h341;
         e.ca1 = 12'h342;
      end else begin
         has = 1;
         v = 0;
         case (b.src)
            3'd1: v = b.alu;
            3'd2: v = b.mdata;
            3'd3: v = b.snpc;
            3'd4: v = b.csr;
            3'd5: v = {31'b0, b.cmp};
            default: has = 0;
         endcase
         if (has && b.rd != 0) m_gpr[b.rd] = v;
         if (b.src == 3'd4) begin
            case (b.ca)
               12'h300: m_mstatus = b.src2;
               12'h305: m_mtvec = b.src2;
               12'h341: m_mepc = b.src2;
               12'h342: m_mcause = b.src2;
               default: ;
            endcase
         end
         e.npc = b.dnpc;
         e.ca0 = b.ca;
         e.ca1 = 12'h305;
      end
      e.rv = m_gpr[b.rd];
      e.cv0 = mcsr(e.ca0);
      e.cv1 = mcsr(e.ca1);
      q.push_back(e);
   endtask

   task automatic issue(bun_t b, int stall);
      int n = 0;
      @(negedge clk);
      pcW = b.pc; dnpcW = b.dnpc; snpcW = b.snpc;
      mdataW = b.mdata; ALU_resultW = b.alu; csrW = b.csr;
      src2W = b.src2; csraddrW = b.ca; rdregsrcW = b.src;
      cmp_resultW = b.cmp; ecallW = b.ec; rdW = b.rd;
      s_valid = 1;
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         chk("accept_timeout", 0, 1);
         s_valid = 0;
         return;
      end
      model_step(b, stall, cyc + 1);
      @(posedge clk);
      #1;
      s_valid = 0;
      pcW = $urandom; ALU_resultW = $urandom; rdW = 5'($urandom);
      rdregsrcW = 3'($urandom); ecallW = 1'($urandom);
   endtask

   function automatic bun_t rnd_bun();
      bun_t b;
      logic [11:0] cas [5];
      cas[0] = 12'h300; cas[1] = 12'h305; cas[2] = 12'h341;
      cas[3] = 12'h342; cas[4] = 12'h123;
      b.pc = $urandom & 32'hFFFF_FFFC;
      b.dnpc = $urandom;
      b.snpc = b.pc + 4;
      b.mdata = $urandom;
      b.alu = $urandom;
      b.csr = $urandom;
      b.src2 = $urandom;
      b.ca = cas[$urandom_range(0, 4)];
      b.src = 3'($urandom);
      b.cmp = 1'($urandom);
      b.ec = ($urandom_range(0, 7) == 0);
      b.rd = 5'($urandom);
      return b;
   endfunction

   // Monitor: checks each presented commit and drives commit_ready.
   logic seen = 0, rdy_chk = 0;
   int   stall_cnt = 0;
   always @(negedge clk) begin
      if (mon_en) begin
         if (commit_valid) begin
            if (q.size() == 0) begin
               chk("spurious_commit", 1, 0);
               commit_ready = 1;
            end else begin
               if (!seen) begin
                  seen = 1;
                  stall_cnt = q[0].stall;
                  chk("latency", cyc, q[0].acc + 1);
                  rs1_addr = q[0].rd;
                  mon_raddr = q[0].ca0;
                  #1;
                  chk("gpr", rs1_data, q[0].rv);
                  chk("csr0", csr_rdata, q[0].cv0);
                  mon_raddr = q[0].ca1;
                  #1;
                  chk("csr1", csr_rdata, q[0].cv1);
               end
               chk("commit_pc", commit_pc, q[0].pc);
               chk("commit_npc", commit_npc, q[0].npc);
               chk("s_ready_busy", s_ready, 0);
               if (stall_cnt > 0) begin
                  stall_cnt--;
                  commit_ready = 0;
               end else begin
                  commit_ready = ($urandom_range(0, 2) != 0);
               end
               if (commit_ready) begin
                  void'(q.pop_front());
                  seen = 0;
                  rdy_chk = 1;
               end
            end
         end else if (rdy_chk) begin
            rdy_chk = 0;
            chk("s_ready_after", s_ready, 1);
         end
      end
   end

   initial begin
      bun_t b;
      int n;
      model_reset();
      #12;
      chk("rst_s_ready", s_ready, 0);
      chk("rst_cvalid", commit_valid, 0);
      @(negedge clk);
      rst = 1;
      #1;
      chk("s_ready_rel", s_ready, 1);
      main_raddr = 12'h300;
      rs2_addr = 5;
      #1;
      chk("mstatus_rst", csr_rdata, 32'h1800);
      chk("x5_rst", rs2_data, 0);
      main_sel = 0;

      b = rnd_bun();
      b.ec = 0;
      b.pc = 32'h8000_0000; b.rd = 5; b.src = 1; b.alu = 32'h1234;
      b.dnpc = 32'h8000_0004;
      issue(b, 0);
      b.rd = 0; b.alu = 32'hFFFF_FFFF; b.pc = 32'h8000_0004;
      issue(b, 0);
      b.src = 4; b.ca = 12'h305; b.src2 = 32'h8000_1000;
      issue(b, 0);
      b.rd = 6; b.csr = 32'h8000_1000; b.src2 = 32'h8000_2000;
      issue(b, 0);
      b.pc = 32'h8000_0010; b.ec = 1; b.rd = 7; b.src = 1;
      issue(b, 0);
      b = rnd_bun();
      b.ec = 0;
      issue(b, 5);
      b = rnd_bun();
      issue(b, 0);

      for (int i = 0; i < 200; i++) begin
         b = rnd_bun();
         issue(b, $urandom_range(0, 3) == 0 ? $urandom_range(1, 4) : 0);
      end

      n = 0;
      while (q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain", q.size(), 0);

      // Reset while a commit is pending.
      b = rnd_bun();
      b.ec = 0; b.rd = 5; b.src = 1; b.alu = 32'hDEAD_BEEF;
      issue(b, 1000);
      n = 0;
      while (!commit_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("pre_rst_cvalid", commit_valid, 1);
      mon_en = 0;
      #2;
      rst = 0;
      #1;
      chk("midrst_cvalid", commit_valid, 0);
      chk("midrst_s_ready", s_ready, 0);
      chk("midrst_npc", commit_npc, 0);
      @(negedge clk);
      rst = 1;
      q.delete();
      model_reset();
      main_sel = 1;
      main_raddr = 12'h300;
      rs2_addr = 5;
      #1;
      chk("post_s_ready", s_ready, 1);
      chk("post_mstatus", csr_rdata, m_mstatus);
      chk("post_x5", rs2_data, m_gpr[5]);
      main_raddr = 12'h305;
      #1;
      chk("post_mtvec", csr_rdata, m_mtvec);

      $display("test done: total=%0d bad=%0d", cnt, bad);
      $finish;
   end

endmodule

// File: doc/wb_commit.md
# wb_commit

Writeback/commit stage: the receiving end of the M→W valid/ready bundle. It accepts one retiring instruction per handshake and selects the destination-register value. It performs the GPR and CSR writes, including ecall trap entry, then offers the resolved next PC to the IFU on a commit handshake. It owns the architectural GPR file and the machine CSRs, and exposes combinational read ports to the decode stage.

## Interface
- NGPR, 32, number of GPRs; x0 hardwired to zero
- RESET_MSTATUS, 32'h0000_1800, mstatus reset value
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- s_valid  in  1  upstream bundle valid
- s_ready  out  1  block can accept a bundle
- dnpcW, snpcW, pcW  in  32 each  next PC, pc+4, instruction PC
- rdregsrcW  in  3  rd source select
- mdataW, ALU_resultW, csrW, src2W  in  32 each  load data, ALU result, old CSR value, CSR write data
- csraddrW  in  12  CSR address
- cmp_resultW, ecallW  in  1 each  compare result, ecall flag
- rdW  in  5  destination register
- rs1_addr, rs2_addr  in  5 each  GPR read addresses
- rs1_data, rs2_data  out  32 each  combinational GPR read data
- csr_raddr  in  12  CSR read address
- csr_rdata  out  32  combinational CSR read data; 0 if unmapped
- commit_valid  out  1  commit record valid
- commit_ready  in  1  IFU accepts commit
- commit_pc, commit_npc  out  32 each  retired PC, fetch target

## Operation
- rdregsrc encoding: 0 none, 1 ALU_result, 2 mdata, 3 snpc, 4 csr, 5 {31'b0, cmp_result}, 6–7 none.
- Source 4 (csrrw) writes csr[csraddr] ← src2 and rd ← old csr value (csrW), in the same cycle.
- Writes to x0 are discarded. rd_addr 0 with any source produces no GPR write.
- Mapped CSRs: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342. Writes to any other address are dropped.
- ecall: mepc ← pc, mcause ← 32'd11, no GPR write, commit_npc = mtvec. An ecall bundle ignores rdregsrc.
- All other bundles: commit_npc = dnpc.
- Read ports are combinational on current register state; there is no write-to-read bypass.
- FSM states:
  - IDLE: s_ready=1. Go to WRITE on s_valid, capturing the whole bundle.
  - WRITE: GPR/CSR update at the end of this cycle. Go to COMMIT.
  - COMMIT: commit_valid=1. Go to IDLE on commit_ready.
- The codes 2'b11 is illegal and goes to IDLE.

## Timing
- Reset (rst low, asynchronous):
  - state IDLE; s_ready=0 while rst is low.
  - commit_valid=0, commit_pc=0, commit_npc=0, captured bundle cleared.
  - GPRs 0; mstatus=RESET_MSTATUS; mtvec, mepc, mcause 0.
- Latency:
  - Bundle accepted at edge N.
  - Architectural write at edge N+1.
  - commit_valid high from after N+1 until the edge where commit_ready=1.
  - Minimum 3 cycles per instruction.
- s_ready=0 in WRITE and COMMIT, so a back-to-back s_valid waits.
- Input fields are don't-care except at the acceptance edge.
- commit_pc and commit_npc are registered and stable while commit_valid=1.
- commit_ready held high: COMMIT lasts exactly one cycle.
- Reset asserted mid-WRITE: the pending write is lost. Reset asserted mid-COMMIT: the commit is dropped.

## Structure
- Shared package wb_pkg holds:
  - rdregsrc codes, CSR address constants, mcause ECALL_M=11
  - FSM state encoding
- One sub-module, wb_gprfile: NGPR×32 array, 1 write port, 2 combinational read ports, x0 read as zero, async active-low reset.
- CSRs live in wb_commit.

## Test plan
- Reset: rst low mid-COMMIT → commit_valid=0 immediately. After release: s_ready=1, csr_rdata(0x300)=0x1800, rs1_data(x5)=0.
- ALU write: pc=0x80000000, rd=5, src=1, ALU=0x1234 → rs1_data(x5)=0x1234 after N+1. commit_pc=0x80000000, commit_npc=dnpc.
- Write to x0: rd=0, src=1, ALU=0xFFFF_FFFF → rs1_data(x0)=0. Commit still occurs.
- csrrw: mtvec=0x80001000, csraddr=0x305, src=4, csrW=0x80001000, src2=0x80002000, rd=6 → x6=0x80001000, csr_rdata(0x305)=0x80002000.
- ecall: pc=0x80000010, ecall=1 → mepc=0x80000010, mcause=11, commit_npc=mtvec, no GPR change.
- Backpressure: commit_ready low for 5 cycles → commit_valid and commit fields stable, s_ready=0, second s_valid bundle held off, then accepted in the cycle after the commit handshake.
